mem_result_packer: RTL and testbench

- Parametrised next generation of the per-batch SMEM result buffer.
- Collects compressed MEM entries, per-read mem_size and per-read ret values from the SMEM pipeline for one batch.
- Once every read has reported, drains the batch to the output arbiter as packed header and body beats.
- Adds over the previous generation: output_ready backpressure, configurable beat width (slots per beat), back-to-back groups with no inter-read gap, explicit batch re-arm, and overflow detection.

---
 rtl/mem_result_packer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mem_result_packer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_result_packer.sv
// mem_result_packer: per-batch SMEM result buffer.
// Collects compressed MEM entries, per-read sizes and ret values for one batch.
// Then drains the batch to the output arbiter as header and body beats, with backpressure.
module mem_result_packer #(
  parameter int MAX_READ = 64,
  parameter int MAX_MEM  = 40,
  parameter int SLOTS    = 2,
  parameter int ENTRY_W  = 113,
  localparam int READ_NUM_W = $clog2(MAX_READ),
  localparam int OUT_W      = 256 * SLOTS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  batch_start,
  input  logic [READ_NUM_W:0]   batch_size,
  input  logic                  mem_we,
  input  logic [READ_NUM_W-1:0] mem_read_num,
  input  logic [6:0]            mem_addr,
  input  logic [255:0]          mem_data,
  input  logic                  mem_size_valid,
  input  logic [6:0]            mem_size,
  input  logic [READ_NUM_W-1:0] mem_size_read_num,
  input  logic                  ret_valid,
  input  logic [6:0]            ret,
  input  logic [READ_NUM_W-1:0] ret_read_num,
  output logic                  output_request,
  input  logic                  output_permit,
  input  logic                  output_ready,
  output logic [OUT_W-1:0]      output_data,
  output logic                  output_valid,
  output logic                  output_finish,
  output logic                  overflow_err
);

  localparam int CNT_W   = READ_NUM_W + 1;
  localparam int SLOT_SH = $clog2(SLOTS);
  // The entry RAM is split into SLOTS banks (bank = entry index mod SLOTS),
  // so a whole beat's worth of entries comes out of one read cycle.
  localparam int ROWS    = (MAX_MEM + SLOTS - 1) / SLOTS;
  localparam int DEPTH   = MAX_READ * ROWS;
  localparam int ROW_W   = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, COLLECT, REQ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      batch_size_q, batch_size_d;
  logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  finish_q, finish_d;
  logic                  request_q, request_d;
  logic [CNT_W-1:0]      cur_read_q, cur_read_d;
  logic [6:0]            beat_q, beat_d;
  logic                  hdr_phase_q, hdr_phase_d;
  logic                  seq_done_q, seq_done_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_hdr_q, s1_hdr_d;
  logic [READ_NUM_W-1:0] s1_read_q, s1_read_d;
  logic [6:0]            s1_size_q, s1_size_d;
  logic [6:0]            s1_ret_q, s1_ret_d;
  logic [SLOTS-1:0]      s1_mask_q, s1_mask_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;

  logic [6:0]            size_mem [MAX_READ];
  logic [6:0]            ret_mem  [MAX_READ];
  logic [ENTRY_W-1:0]    bank_rd  [SLOTS];

  logic                  wr_en, rd_en, adv, fire, issue, last_read;
  logic [6:0]            wr_slot, size_clip, cur_size, cur_ret;
  logic [ROW_W-1:0]      wr_row, rd_row;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [READ_NUM_W-1:0] cur_r;
  logic [7:0]            nbeats;
  logic [SLOTS-1:0]      slot_mask;
  logic [OUT_W-1:0]      beat_data;
  logic                  unused_data_bits;

  function automatic logic [255:0] expand(input logic [ENTRY_W-1:0] e);
    logic [255:0] s;
    s            = '0;
    s[230:224]   = e[112:106];
    s[198:192]   = e[105:99];
    s[160:128]   = e[98:66];
    s[96:64]     = e[65:33];
    s[32:0]      = e[32:0];
    return s;
  endfunction

  assign wr_entry  = {mem_data[230:224], mem_data[198:192], mem_data[160:128],
                      mem_data[96:64], mem_data[32:0]};
  assign unused_data_bits = ^{mem_data[255:231], mem_data[223:199], mem_data[191:161],
                              mem_data[127:97], mem_data[63:33]};
  assign size_clip = (mem_size > 7'(MAX_MEM)) ? 7'(MAX_MEM) : mem_size;
  assign wr_en     = mem_we && (state_q == COLLECT) && (mem_addr < 7'(MAX_MEM));
  assign wr_slot   = mem_addr & 7'(SLOTS - 1);
  assign wr_row    = ROW_W'(mem_read_num) * ROW_W'(ROWS) + ROW_W'(mem_addr >> SLOT_SH);

  // Sequencer view of the read currently being issued.
  assign cur_r     = cur_read_q[READ_NUM_W-1:0];
  assign cur_size  = size_mem[cur_r];
  assign cur_ret   = ret_mem[cur_r];
  assign nbeats    = ({1'b0, cur_size} + 8'(SLOTS - 1)) >> SLOT_SH;
  assign last_read = (cur_read_q + CNT_W'(1)) == batch_size_q;
  assign rd_row    = ROW_W'(cur_r) * ROW_W'(ROWS) + ROW_W'(beat_q);

  // The whole pipeline moves only when the output slot is free or being taken.
  assign fire  = out_valid_q && output_ready;
  assign adv   = output_permit && (!out_valid_q || output_ready);
  assign issue = adv && ((state_q == REQ) || (state_q == DRAIN)) && !seq_done_q;
  assign rd_en = issue;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_bank
      logic [ENTRY_W-1:0] ram [DEPTH];
      logic [ENTRY_W-1:0] rd_word;
      // One bank: single write port, registered read that holds while stalled.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_slot == 7'(gi))) ram[wr_row] <= wr_entry;
        if (rd_en) rd_word <= ram[rd_row];
      end
      assign bank_rd[gi] = rd_word;
    end
  endgenerate

  // Per-read size and ret register file, written straight from the report strobes.
  always_ff @(posedge clk) begin
    if (mem_size_valid) size_mem[mem_size_read_num] <= size_clip;
    if (ret_valid && (state_q != IDLE)) ret_mem[ret_read_num] <= ret;
  end

  // Which slots of the body beat being issued lie inside the read's mem_size.
  always_comb begin
    slot_mask = '0;
    for (int k = 0; k < SLOTS; k++)
      slot_mask[k] = (int'(beat_q) * SLOTS + k) < int'(cur_size);
  end

  // Assemble the beat held in stage 1 (header fields or expanded RAM slots).
  always_comb begin
    beat_data = '0;
    if (s1_hdr_q) begin
      beat_data[9:0]     = 10'(s1_read_q);
      beat_data[70:64]   = s1_size_q;
      beat_data[134:128] = s1_ret_q;
    end else begin
      for (int k = 0; k < SLOTS; k++)
        if (s1_mask_q[k]) beat_data[k*256 +: 256] = expand(bank_rd[k]);
    end
  end

  // Next-state logic: batch control, error flags, beat sequencer and output pipeline.
  always_comb begin
    state_d      = state_q;
    batch_size_d = batch_size_q;
    done_cnt_d   = done_cnt_q;
    overflow_d   = overflow_q;
    finish_d     = finish_q;
    cur_read_d   = cur_read_q;
    beat_d       = beat_q;
    hdr_phase_d  = hdr_phase_q;
    seq_done_d   = seq_done_q;
    s1_valid_d   = s1_valid_q;
    s1_hdr_d     = s1_hdr_q;
    s1_read_d    = s1_read_q;
    s1_size_d    = s1_size_q;
    s1_ret_d     = s1_ret_q;
    s1_mask_d    = s1_mask_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (mem_size_valid) done_cnt_d = done_cnt_q + CNT_W'(1);
    if (mem_we && ((mem_addr >= 7'(MAX_MEM)) || (state_q != COLLECT))) overflow_d = 1'b1;
    if (mem_size_valid && (mem_size > 7'(MAX_MEM))) overflow_d = 1'b1;

    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = beat_data;
      s1_valid_d = issue;
      if (issue) begin
        s1_hdr_d  = hdr_phase_q;
        s1_read_d = cur_r;
        s1_size_d = cur_size;
        s1_ret_d  = cur_ret;
        s1_mask_d = slot_mask;
        if (hdr_phase_q && (nbeats != 8'd0)) begin
          hdr_phase_d = 1'b0;
          beat_d      = '0;
        end else if (!hdr_phase_q && (({1'b0, beat_q} + 8'd1) != nbeats)) begin
          beat_d = beat_q + 7'd1;
        end else begin
          hdr_phase_d = 1'b1;
          beat_d      = '0;
          cur_read_d  = cur_read_q + CNT_W'(1);
          if (last_read) seq_done_d = 1'b1;
        end
      end
    end else if (fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: if (done_cnt_q == batch_size_q) state_d = REQ;
      REQ:     if (output_permit) state_d = DRAIN;
      DRAIN: begin
        if (seq_done_q && !s1_valid_q && (!out_valid_q || fire)) begin
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A new batch aborts whatever is in flight.
    if (batch_start) begin
      batch_size_d = batch_size;
      done_cnt_d   = '0;
      overflow_d   = 1'b0;
      cur_read_d   = '0;
      beat_d       = '0;
      hdr_phase_d  = 1'b1;
      seq_done_d   = 1'b0;
      s1_valid_d   = 1'b0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      state_d      = (batch_size == '0) ? DONE : COLLECT;
      finish_d     = (batch_size == '0);
    end
  end

  assign request_d = (state_d == REQ) || (state_d == DRAIN);

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      batch_size_q <= '0;
      done_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      finish_q     <= 1'b0;
      request_q    <= 1'b0;
      cur_read_q   <= '0;
      beat_q       <= '0;
      hdr_phase_q  <= 1'b1;
      seq_done_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_hdr_q     <= 1'b0;
      s1_read_q    <= '0;
      s1_size_q    <= '0;
      s1_ret_q     <= '0;
      s1_mask_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      batch_size_q <= batch_size_d;
      done_cnt_q   <= done_cnt_d;
      overflow_q   <= overflow_d;
      finish_q     <= finish_d;
      request_q    <= request_d;
      cur_read_q   <= cur_read_d;
      beat_q       <= beat_d;
      hdr_phase_q  <= hdr_phase_d;
      seq_done_q   <= seq_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_hdr_q     <= s1_hdr_d;
      s1_read_q    <= s1_read_d;
      s1_size_q    <= s1_size_d;
      s1_ret_q     <= s1_ret_d;
      s1_mask_q    <= s1_mask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign output_request = request_q;
  assign output_data    = out_data_q;
  assign output_valid   = out_valid_q;
  assign output_finish  = finish_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_mem_result_packer.sv
// Directed testbench for mem_result_packer: a SLOTS=2 and a SLOTS=4 instance share stimulus.
module tb_mem_result_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, batch_start, mem_we, mem_size_valid, ret_valid;
  logic         output_permit, output_ready;
  logic [6:0]   batch_size, mem_addr, mem_size, ret;
  logic [5:0]   mem_read_num, mem_size_read_num, ret_read_num;
  logic [255:0] mem_data;

  logic          req2, valid2, fin2, ovf2;
  logic [511:0]  data2;
  logic          req4, valid4, fin4, ovf4;
  logic [1023:0] data4;

  int errors = 0;
  int checks = 0;

  logic [511:0]  q2[$];
  logic [1023:0] q4[$];
  int stall_bad, timeout, vcnt2, first2, last2, fin2_at;

  mem_result_packer #(.MAX_READ(64), .MAX_MEM(40), .SLOTS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .batch_start(batch_start), .batch_size(batch_size),
    .mem_we(mem_we), .mem_read_num(mem_read_num), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_size_valid(mem_size_valid), .mem_size(mem_size), .mem_size_read_num(mem_size_read_num),
    .ret_valid(ret_valid), .ret(ret), .ret_read_num(ret_read_num),
    .output_request(req2), .output_permit(output_permit), .output_ready(output_ready),
    .output_data(data2), .output_valid(valid2), .output_finish(fin2), .overflow_err(ovf2)
  );

  mem_result_packer #(.MAX_READ(64), .MAX_MEM(40), .SLOTS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .batch_start(batch_start), .batch_size(batch_size),
    .mem_we(mem_we), .mem_read_num(mem_read_num), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_size_valid(mem_size_valid), .mem_size(mem_size), .mem_size_read_num(mem_size_read_num),
    .ret_valid(ret_valid), .ret(ret), .ret_read_num(ret_read_num),
    .output_request(req4), .output_permit(output_permit), .output_ready(output_ready),
    .output_data(data4), .output_valid(valid4), .output_finish(fin4), .overflow_err(ovf4)
  );

  // Expected 256-bit slot for entry (r, a): fields in place, everything else zero.
  function automatic logic [255:0] mk_slot(input int r, input int a);
    logic [255:0] v;
    v          = '0;
    v[32:0]    = {1'b1, 8'h00, r[7:0], a[7:0], 8'hA5};
    v[96:64]   = {1'b0, 16'hBEEF, r[7:0], a[7:0]};
    v[160:128] = {1'b1, 24'h123456, a[7:0]};
    v[198:192] = 7'(a + 3);
    v[230:224] = 7'(r + 10);
    return v;
  endfunction

  // Input word: same fields with every non-stored bit set to 1.
  function automatic logic [255:0] mk_in(input int r, input int a);
    logic [255:0] m;
    m          = '0;
    m[32:0]    = '1;
    m[96:64]   = '1;
    m[160:128] = '1;
    m[198:192] = '1;
    m[230:224] = '1;
    return mk_slot(r, a) | ~m;
  endfunction

  function automatic logic [255:0] hdr(input int r, input int s, input int t);
    logic [255:0] h;
    h          = '0;
    h[9:0]     = 10'(r);
    h[70:64]   = 7'(s);
    h[134:128] = 7'(t);
    return h;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input int n);
    batch_start = 1'b1;
    batch_size  = 7'(n);
    tick();
    batch_start = 1'b0;
  endtask

  task automatic write_entry(input int r, input int a);
    mem_we       = 1'b1;
    mem_read_num = 6'(r);
    mem_addr     = 7'(a);
    mem_data     = mk_in(r, a);
    tick();
    mem_we       = 1'b0;
  endtask

  task automatic report(input int r, input int s, input int t);
    mem_size_valid    = 1'b1;
    mem_size          = 7'(s);
    mem_size_read_num = 6'(r);
    ret_valid         = 1'b1;
    ret               = 7'(t);
    ret_read_num      = 6'(r);
    tick();
    mem_size_valid    = 1'b0;
    ret_valid         = 1'b0;
  endtask

  task automatic load_std;
    start_batch(2);
    for (int a = 0; a < 3; a++) write_entry(0, a);
    report(0, 3, 5);
    report(1, 0, 9);
  endtask

  // Grants the drain and records every transferred beat; mode 1 toggles ready 1,0,0.
  task automatic run_drain(input int mode, input int bound);
    logic [511:0]  held2;
    logic [1023:0] held4;
    logic          held2_v, held4_v, rdy;
    q2.delete();
    q4.delete();
    stall_bad = 0; timeout = 1; vcnt2 = 0; first2 = -1; last2 = -1; fin2_at = -1;
    held2_v = 1'b0; held4_v = 1'b0; held2 = '0; held4 = '0;
    output_permit = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (held2_v && (!valid2 || (data2 !== held2))) stall_bad++;
      if (held4_v && (!valid4 || (data4 !== held4))) stall_bad++;
      if (fin2 && (fin2_at < 0)) fin2_at = i;
      if (fin2 && fin4) begin
        timeout = 0;
        break;
      end
      rdy = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      output_ready = rdy;
      if (valid2) begin
        vcnt2++;
        if (first2 < 0) first2 = i;
      end
      if (valid2 && rdy) begin
        q2.push_back(data2);
        last2 = i;
        $display("xfer slots2 #%0d data[143:0]=%h", q2.size() - 1, data2[143:0]);
      end
      if (valid4 && rdy) begin
        q4.push_back(data4);
        $display("xfer slots4 #%0d data[143:0]=%h", q4.size() - 1, data4[143:0]);
      end
      held2_v = valid2 && !rdy; held2 = data2;
      held4_v = valid4 && !rdy; held4 = data4;
      tick();
    end
    output_permit = 1'b0;
    output_ready  = 1'b0;
  endtask

  task automatic check_std_beats(input string tag);
    logic [511:0] exp [4];
    exp[0] = {256'd0, hdr(0, 3, 5)};
    exp[1] = {mk_slot(0, 1), mk_slot(0, 0)};
    exp[2] = {256'd0, mk_slot(0, 2)};
    exp[3] = {256'd0, hdr(1, 0, 9)};
    checks++;
    if (timeout !== 0) begin errors++; $display("FAIL %s_timeout: finish not reached", tag); end
    checks++;
    if (q2.size() !== 4) begin errors++; $display("FAIL %s_count: got %0d want 4", tag, q2.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < q2.size()) begin
        checks++;
        if (q2[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_beat%0d: got %h want %h", tag, i, q2[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL reset_request: got %b want 0", req2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid2); end
    checks++; if (fin2 !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b want 0", fin2); end
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf2); end
    checks++; if (data2 !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data2); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    load_std();
    tick();
    checks++; if (req2 !== 1'b1) begin errors++; $display("FAIL basic_request: got %b want 1", req2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b want 0", valid2); end
    run_drain(0, 60);
    check_std_beats("basic");
    checks++; if (vcnt2 !== 4) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 4", vcnt2); end
    checks++;
    if (last2 - first2 + 1 !== 4) begin
      errors++; $display("FAIL basic_back_to_back: got span %0d want 4", last2 - first2 + 1);
    end
    checks++;
    if (fin2_at !== last2 + 1) begin
      errors++; $display("FAIL basic_finish_time: got %0d want %0d", fin2_at, last2 + 1);
    end
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL basic_request_done: got %b want 0", req2); end
  endtask

  task automatic test_backpressure;
    load_std();
    tick();
    run_drain(1, 100);
    check_std_beats("stall");
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
    checks++; if (fin2 !== 1'b1) begin errors++; $display("FAIL stall_finish: got %b want 1", fin2); end
  endtask

  task automatic test_slots4;
    logic [1023:0] w;
    logic [255:0]  want;
    start_batch(1);
    for (int a = 0; a < 5; a++) write_entry(0, a);
    report(0, 5, 7);
    tick();
    run_drain(0, 60);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL s4_timeout: finish not reached"); end
    checks++; if (q4.size() !== 3) begin errors++; $display("FAIL s4_count: got %0d want 3", q4.size()); end
    checks++; if (q2.size() !== 4) begin errors++; $display("FAIL s4_slots2_count: got %0d want 4", q2.size()); end
    for (int b = 0; b < 3; b++) begin
      if (b < q4.size()) begin
        w = q4[b];
        for (int k = 0; k < 4; k++) begin
          if (b == 0)      want = (k == 0) ? hdr(0, 5, 7) : 256'd0;
          else if (b == 1) want = mk_slot(0, k);
          else             want = (k == 0) ? mk_slot(0, 4) : 256'd0;
          checks++;
          if (w[k*256 +: 256] !== want) begin
            errors++; $display("FAIL s4_beat%0d_slot%0d: got %h want %h", b, k, w[k*256 +: 256], want);
          end
        end
      end
    end
    if (q4.size() == 3) begin
      w = q4[2];
      checks++;
      if (w[32:0] !== 33'h1_0000_04A5) begin
        errors++; $display("FAIL s4_px0: got %h want 1000004a5", w[32:0]);
      end
      checks++;
      if (w[230:224] !== 7'd10) begin
        errors++; $display("FAIL s4_pinfo: got %0d want 10", w[230:224]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [1023:0] w;
    start_batch(1);
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL ovf_start: got %b want 0", ovf2); end
    write_entry(0, 40);
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_addr: got %b want 1", ovf2); end
    write_entry(0, 0);
    report(0, 50, 3);
    tick();
    run_drain(0, 200);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL ovf_timeout: finish not reached"); end
    checks++; if (q2.size() !== 21) begin errors++; $display("FAIL ovf_count: got %0d want 21", q2.size()); end
    if (q2.size() > 0) begin
      checks++;
      if (q2[0] !== {256'd0, hdr(0, 40, 3)}) begin
        errors++; $display("FAIL ovf_header: got %h want %h", q2[0], {256'd0, hdr(0, 40, 3)});
      end
    end
    checks++; if (q4.size() !== 11) begin errors++; $display("FAIL ovf_count4: got %0d want 11", q4.size()); end
    if (q4.size() > 0) begin
      w = q4[0];
      checks++;
      if (w[255:0] !== hdr(0, 40, 3)) begin
        errors++; $display("FAIL ovf_header4: got %h want %h", w[255:0], hdr(0, 40, 3));
      end
    end
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf4); end
  endtask

  task automatic test_zero_batch;
    int req_seen, valid_seen;
    start_batch(0);
    checks++; if (fin2 !== 1'b1) begin errors++; $display("FAIL zero_finish: got %b want 1", fin2); end
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL zero_ovf_cleared: got %b want 0", ovf2); end
    req_seen = 0; valid_seen = 0;
    output_permit = 1'b1;
    output_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (req2 || req4) req_seen++;
      if (valid2 || valid4) valid_seen++;
      tick();
    end
    output_permit = 1'b0;
    output_ready  = 1'b0;
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL zero_request: got %0d cycles want 0", req_seen); end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL zero_valid: got %0d cycles want 0", valid_seen); end
    write_entry(0, 0);
    checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL zero_write_outside: got %b want 1", ovf2); end
  endtask

  task automatic test_reset_mid_drain;
    int seen;
    load_std();
    tick();
    output_permit = 1'b1;
    output_ready  = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid2) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL mid_first_valid: got %0d want 1", seen); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid2); end
    checks++; if (req2 !== 1'b0) begin errors++; $display("FAIL mid_request: got %b want 0", req2); end
    checks++; if (data2 !== '0) begin errors++; $display("FAIL mid_data: got %h want 0", data2); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL mid_valid4: got %b want 0", valid4); end
    output_permit = 1'b0;
    output_ready  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    load_std();
    tick();
    run_drain(0, 60);
    check_std_beats("rerun");
  endtask

  initial begin
    reset_n = 1'b0; batch_start = 1'b0; batch_size = '0; mem_we = 1'b0;
    mem_read_num = '0; mem_addr = '0; mem_data = '0; mem_size_valid = 1'b0;
    mem_size = '0; mem_size_read_num = '0; ret_valid = 1'b0; ret = '0;
    ret_read_num = '0; output_permit = 1'b0; output_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_slots4();
    test_overflow();
    test_zero_batch();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
